// File: rtl/countdown_timer.sv
// countdown_timer: HH:MM:SS down-counter clocked by a 1 Hz edge.
// Host loads a duration, starts/pauses/resumes, and acknowledges the expiry
// alarm. done holds for ALARM_HOLD cycles after the count reaches zero.
module countdown_timer #(
  parameter int MAX_HOURS  = 23,
  parameter int ALARM_HOLD = 10
) (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  input  logic       start,
  input  logic       pause,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       done,
  output logic       expired
);

  // Hold counter only needs to reach ALARM_HOLD-1.
  localparam int HW = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;
  localparam logic [4:0]    MAX_H    = 5'(MAX_HOURS);
  localparam logic [HW-1:0] HOLD_TOP = HW'(ALARM_HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, ALARM} state_t;

  state_t        state, state_nxt;
  logic [4:0]    h_nxt;
  logic [5:0]    m_nxt, s_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic          expired_nxt;
  logic          cnt_zero, cnt_last;

  assign cnt_zero = (hours == '0) && (minutes == '0) && (seconds == '0);
  // Final second: this decrement lands on zero. A zero count in RUN is
  // unreachable, but is treated the same so the timer can never wrap.
  assign cnt_last = (hours == '0) && (minutes == '0) && (seconds <= 6'd1);

  // running/done decode the state register directly, so they stay registered.
  assign running = (state == RUN);
  assign done    = (state == ALARM);

  // Next-state and next-count logic; priority load > start > pause.
  always_comb begin
    state_nxt   = state;
    h_nxt       = hours;
    m_nxt       = minutes;
    s_nxt       = seconds;
    hold_nxt    = hold;
    expired_nxt = 1'b0;
    if (load) begin
      state_nxt = IDLE;
      hold_nxt  = '0;
      h_nxt     = (load_hours   > MAX_H) ? MAX_H : load_hours;
      m_nxt     = (load_minutes > 6'd59) ? 6'd59 : load_minutes;
      s_nxt     = (load_seconds > 6'd59) ? 6'd59 : load_seconds;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cnt_zero) state_nxt = RUN;
        end
        RUN: begin
          // start outranks pause, so start+pause keeps the timer running.
          if (pause && !start) begin
            state_nxt = PAUSED;
          end else if (cnt_last) begin
            state_nxt   = ALARM;
            h_nxt       = '0;
            m_nxt       = '0;
            s_nxt       = '0;
            hold_nxt    = HOLD_TOP;
            expired_nxt = 1'b1;
          end else if (seconds != '0) begin
            s_nxt = seconds - 6'd1;
          end else if (minutes != '0) begin
            s_nxt = 6'd59;
            m_nxt = minutes - 6'd1;
          end else begin
            s_nxt = 6'd59;
            m_nxt = 6'd59;
            h_nxt = hours - 5'd1;
          end
        end
        PAUSED: begin
          if (start) state_nxt = RUN;
        end
        ALARM: begin
          if (start || hold == '0) begin
            state_nxt = IDLE;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, count and alarm registers with synchronous reset.
  always_ff @(posedge Clk_1sec) begin
    if (reset) begin
      state   <= IDLE;
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
      hold    <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      hours   <= h_nxt;
      minutes <= m_nxt;
      seconds <= s_nxt;
      hold    <= hold_nxt;
      expired <= expired_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: load/start/pause/alarm sequences with
// hand-computed expected counts, checked by immediate assertions.
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [4:0] load_hours = '0;
  logic [5:0] load_minutes = '0, load_seconds = '0;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       running, done, expired;
  int         errors = 0, checks = 0;

  countdown_timer #(.MAX_HOURS(23), .ALARM_HOLD(10)) dut (
    .Clk_1sec(clk), .reset(reset), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .start(start), .pause(pause),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int h, input int m, input int s);
    chk({tag, ".h"}, 32'(hours),   32'(h));
    chk({tag, ".m"}, 32'(minutes), 32'(m));
    chk({tag, ".s"}, 32'(seconds), 32'(s));
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1;
    load_hours = 5'(h); load_minutes = 6'(m); load_seconds = 6'(s);
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    // 1: reset
    #2;
    reset = 1'b1;
    tick();
    chk_cnt("rst1", 0, 0, 0);
    tick();
    chk_cnt("rst2", 0, 0, 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done",    32'(done),    0);
    chk("rst_expired", 32'(expired), 0);
    reset = 1'b0;

    // 2: 0:01:05 run to expiry
    do_load(0, 1, 5);
    chk_cnt("ld105", 0, 1, 5);
    chk("ld105_run", 32'(running), 0);
    do_start();
    chk("st_running", 32'(running), 1);
    chk_cnt("st_nodec", 0, 1, 5);
    tick();
    chk_cnt("first_dec", 0, 1, 4);
    ticks(63);
    chk_cnt("at_one", 0, 0, 1);
    chk("at_one_exp", 32'(expired), 0);
    tick();
    chk_cnt("at_zero", 0, 0, 0);
    chk("exp_pulse", 32'(expired), 1);
    chk("done_on",   32'(done),    1);
    chk("run_off",   32'(running), 0);
    cnt = 1;
    tick();
    chk("exp_one_cycle", 32'(expired), 0);
    if (done) cnt++;
    for (int i = 0; i < 20 && done; i++) begin
      tick();
      if (done) cnt++;
    end
    chk("done_cycles", 32'(cnt), 10);
    chk("after_alarm_done", 32'(done), 0);
    chk("after_alarm_run",  32'(running), 0);
    chk_cnt("after_alarm", 0, 0, 0);

    // 3: hour borrow and minute borrow
    do_load(1, 0, 0);
    do_start();
    tick();
    chk_cnt("hr_borrow", 0, 59, 59);
    ticks(59);
    chk_cnt("m59s0", 0, 59, 0);
    tick();
    chk_cnt("min_borrow", 0, 58, 59);

    // 4: clamping
    do_load(31, 63, 60);
    chk_cnt("clamp", 23, 59, 59);
    chk("clamp_idle", 32'(running), 0);
    do_load(24, 60, 0);
    chk_cnt("clamp2", 23, 59, 0);

    // 5: pause and resume
    do_load(0, 0, 20);
    do_start();
    ticks(2);
    chk_cnt("pre_pause", 0, 0, 18);
    pause = 1'b1;
    tick();
    chk_cnt("pause1", 0, 0, 18);
    chk("pause1_run", 32'(running), 0);
    ticks(2);
    chk_cnt("pause3", 0, 0, 18);
    chk("pause3_run", 32'(running), 0);
    pause = 1'b0;
    do_start();
    chk("resume_run", 32'(running), 1);
    chk_cnt("resume_nodec", 0, 0, 18);
    tick();
    chk_cnt("resume_dec", 0, 0, 17);

    // 6: zero start ignored, load mid-run, ack during alarm, reset mid-run
    do_load(0, 0, 0);
    do_start();
    chk("zero_start", 32'(running), 0);
    chk_cnt("zero_cnt", 0, 0, 0);
    do_load(0, 0, 30);
    do_start();
    tick();
    chk_cnt("pre_reload", 0, 0, 29);
    do_load(0, 0, 9);
    chk("reload_idle", 32'(running), 0);
    chk_cnt("reload", 0, 0, 9);
    do_start();
    ticks(9);
    chk("alarm9", 32'(done), 1);
    tick();
    do_start();
    chk("ack_done", 32'(done), 0);
    chk("ack_run",  32'(running), 0);
    chk_cnt("ack_cnt", 0, 0, 0);
    do_load(2, 3, 4);
    do_start();
    tick();
    chk_cnt("pre_rst", 2, 3, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cnt("mid_rst", 0, 0, 0);
    chk("mid_rst_run", 32'(running), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
